// File: rtl/stage_sequencer.sv
// stage_sequencer: one-hot multicycle stage strobes with stall, flush, halt, retire count and stall timeout
module stage_sequencer #(
    parameter int NSTAGES = 5,
    parameter int LOOP_TO = 1,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 0
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         enable,
    input  logic [NSTAGES-1:0]                           stage_ready,
    input  logic                                         flush,
    input  logic                                         halt,
    output logic [NSTAGES-1:0]                           stage_onehot,
    output logic [((NSTAGES > 1) ? $clog2(NSTAGES) : 1)-1:0] stage_idx,
    output logic                                         stage_first,
    output logic                                         busy,
    output logic                                         retire,
    output logic [CNT_W-1:0]                             retire_count,
    output logic                                         timeout_err
);
    localparam int IW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
    localparam int SW = $clog2(TIMEOUT + 2);
    localparam logic [IW-1:0] LAST = IW'(NSTAGES - 1);
    localparam logic [IW-1:0] LOOP = IW'(LOOP_TO);
    localparam logic [SW-1:0] TO   = SW'(TIMEOUT);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t        state;
    logic [SW-1:0] stallCnt;
    logic [SW-1:0] stallNext;

    // Saturating stall count so a long stall never wraps back below the threshold
    assign stallNext = (&stallCnt) ? stallCnt : stallCnt + 1'b1;

    // Strobes are decoded purely from registered state
    assign busy         = (state == ACTIVE);
    assign stage_onehot = busy ? (NSTAGES'(1) << stage_idx) : '0;

    // Stage sequencing: flush beats freeze, freeze beats advance/stall
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            stage_idx    <= '0;
            stage_first  <= 1'b0;
            retire       <= 1'b0;
            retire_count <= '0;
            timeout_err  <= 1'b0;
            stallCnt     <= '0;
        end else begin
            stage_first <= 1'b0;
            retire      <= 1'b0;
            if (state == IDLE) begin
                if (enable && !halt) begin
                    state       <= ACTIVE;
                    stage_idx   <= '0;
                    stage_first <= 1'b1;
                    stallCnt    <= '0;
                end
            end else if (flush) begin
                stage_idx   <= '0;
                stage_first <= 1'b1;
                stallCnt    <= '0;
            end else if (enable) begin
                if (stage_ready[stage_idx]) begin
                    stallCnt <= '0;
                    if (stage_idx == LAST) begin
                        retire       <= 1'b1;
                        retire_count <= retire_count + 1'b1;
                        if (halt) begin
                            state     <= IDLE;
                            stage_idx <= '0;
                        end else begin
                            stage_idx   <= LOOP;
                            stage_first <= 1'b1;
                        end
                    end else begin
                        stage_idx   <= stage_idx + 1'b1;
                        stage_first <= 1'b1;
                    end
                end else begin
                    stallCnt <= stallNext;
                    if (TIMEOUT != 0 && stallNext == TO)
                        timeout_err <= 1'b1;
                end
            end
        end
    end
endmodule
